ether_rx_frame_ctrl: RTL and testbench
======================================

# ether_rx_frame_ctrl

Receive-side frame controller between the GMII receive pins and the packet buffer RAM. It sequences preamble/SFD detection, steers payload bytes into one of two 2 KiB buffer slots (ping-pong), checks length and FCS, and posts a per-frame descriptor to the consumer. It frees a slot on a valid/ack handshake. Frames that cannot be stored cleanly are discarded and counted.

## Interface
Parameters:
- MIN_LEN, 64: minimum frame length in bytes, DA through FCS inclusive.
- MAX_LEN, 1518: maximum frame length in bytes (≤ 2047).
- PRE_MIN, 7: minimum count of 0x55 bytes before SFD.

Ports:
- phy_rx_clk  in  1  receive clock; all logic is on this clock.
- rst  in  1  asynchronous, active-high reset.
- phy_rx_dv  in  1  GMII data valid.
- phy_rx_er  in  1  GMII receive error.
- phy_rx_data  in  8  GMII receive byte.
- buf_we  out  1  buffer RAM write strobe.
- buf_waddr  out  12  {slot, 11-bit byte offset}.
- buf_wdata  out  8  byte to write.
- frm_valid  out  1  a committed frame is pending.
- frm_slot  out  1  slot holding the oldest pending frame.
- frm_len  out  11  length of that frame in bytes, FCS included.
- frm_crc_ok  out  1  FCS residue matched.
- frm_ack  in  1  consumer releases the oldest pending frame.
- drop_cnt  out  16  discarded-frame count; saturates at 0xFFFF.

## Operation
- States: IDLE, PRE, DATA, CHECK, DROP. Encoding lives in the package.
- IDLE: when dv=1 and data=0x55, go to PRE with pre_cnt=1. Any other byte with dv=1 goes to DROP.
- PRE: while dv=1 and data=0x55, pre_cnt increments (saturating at 15).
  - data=0xD5 with pre_cnt ≥ PRE_MIN: if a free slot exists, go to DATA with wr_ptr=0. If no slot is free, go to DROP and count the drop.
  - data=0xD5 with pre_cnt < PRE_MIN, or any other byte, or dv falling: go to DROP. These are not counted, because no frame was started.
- DATA: each dv=1 byte is written to {wr_slot, wr_ptr}, then wr_ptr increments.
  - rx_er=1, or wr_ptr reaching MAX_LEN with dv still high: go to DROP and count the drop.
  - dv=0: go to CHECK.
- CHECK (one cycle):
  - len < MIN_LEN: discard and count, then go to IDLE.
  - Otherwise commit {wr_slot, len, crc_ok} to the descriptor queue, toggle wr_slot, and go to IDLE.
- DROP: wait for dv=0, then go to IDLE. Nothing in DROP is committed.
- Descriptor queue holds 2 entries (one per slot) in arrival order. occ is 0..2 and "free slot" means occ<2.
  - frm_valid = (occ≠0).
  - frm_ack while frm_valid pops the queue. frm_ack while frm_valid=0 is ignored.
  - A commit and an ack in the same cycle both apply, and occ is unchanged.
- Slot reuse: wr_slot always points at the slot not held by a pending frame whenever occ<2.
- Bytes arriving while dv=1 in DROP are never written (buf_we=0).

## Timing
- Reset values:
  - state=IDLE, wr_slot=0, occ=0.
  - buf_we=0, buf_waddr=0, buf_wdata=0.
  - frm_valid=0, frm_slot=0, frm_len=0, frm_crc_ok=0.
  - drop_cnt=0.
- Write path is registered: the byte sampled at edge n appears on buf_* after edge n with buf_we=1, giving 1 cycle latency.
- Descriptor: frm_valid rises 2 cycles after the edge that samples dv=0 (1 cycle in CHECK, then the registered output).
- frm_ack is sampled on the rising edge. Descriptor outputs update on the following edge.
- Reset asserted mid-frame aborts the frame without counting it, clears the queue, and leaves buffer contents undefined.
- drop_cnt updates 1 cycle after the event that decides the drop.

## Configuration
- ETHER_RX_CRC_CHECK_EN defined:
  - Instantiate the CRC-32 unit, cleared at SFD and enabled on every DATA byte.
  - frm_crc_ok=1 iff the final register equals residue 0xC704DD7B.
  - Frames with a bad FCS are still committed, with frm_crc_ok=0.
- ETHER_RX_CRC_CHECK_EN undefined: no CRC logic is built and frm_crc_ok is tied to 1 on every committed frame.

## Structure
- Package ether_rx_pkg holds:
  - state enum;
  - SFD=0xD5 and PRE_BYTE=0x55;
  - CRC_RESIDUE=0xC704DD7B;
  - descriptor struct {slot, len[10:0], crc_ok}.
- One sub-module: ether_rx_crc32 (byte-wide CRC-32 with clear/calc), present only under the macro.
- The descriptor queue is inline as a 2-entry register file with rd/wr pointers.

## Test plan
- 7×0x55, 0xD5, 64-byte frame with valid FCS, dv drop -> 64 writes to slot 0 offsets 0..63; frm_valid=1, frm_slot=0, frm_len=64, frm_crc_ok=1.
- Two valid 100-byte frames with no ack -> slots 0 and 1 pending. A third frame gives drop_cnt=1 and no writes. Two acks then bring frm_valid to 0.
- 64-byte frame with one corrupted payload byte (macro on) -> committed with frm_crc_ok=0. With the macro off -> frm_crc_ok=1.
- rx_er asserted at byte 30 -> no descriptor, drop_cnt +1. Also a 40-byte frame (runt) -> drop_cnt +1, occ unchanged.
- 1600-byte burst -> exactly 1518 writes, then DROP until dv=0, drop_cnt +1, no descriptor.
- Commit and frm_ack in the same cycle with occ=1 -> occ stays 1 and frm_slot advances to the new frame. rst asserted mid-DATA -> all outputs return to reset values.

Source files
------------

// File: rtl/ether_rx_pkg.sv
// Shared types and constants for the GMII receive frame controller.
package ether_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DROP  = 3'd4
    } rx_state_t;

    localparam logic [7:0]  SFD         = 8'hD5;
    localparam logic [7:0]  PRE_BYTE    = 8'h55;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] CRC_POLY    = 32'h04C11DB7;

    typedef struct packed {
        logic        slot;
        logic [10:0] len;
        logic        crc_ok;
    } rx_desc_t;

endpackage

// File: rtl/ether_rx_crc32.sv
// Byte-wide Ethernet CRC-32, MSB-first register with bytes fed LSB first.
// A good frame (payload + FCS) leaves the register at CRC_RESIDUE.
// Only built when ETHER_RX_CRC_CHECK_EN is defined.
`ifdef ETHER_RX_CRC_CHECK_EN
module ether_rx_crc32
    import ether_rx_pkg::*;
(
    input  logic        phy_rx_clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        calc,
    input  logic [7:0]  data,
    output logic [31:0] crc
);

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[31] ^ d[i])
                r = {r[30:0], 1'b0} ^ CRC_POLY;
            else
                r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    // Running CRC: preset at SFD, folded in for every stored byte.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst)
            crc <= 32'hFFFFFFFF;
        else if (clr)
            crc <= 32'hFFFFFFFF;
        else if (calc)
            crc <= crc_step(crc, data);
    end

endmodule
`endif

// File: rtl/ether_rx_frame_ctrl.sv
// GMII receive frame controller: preamble/SFD detection, ping-pong storage
// into two 2 KiB buffer slots, length check, and a 2-deep descriptor queue.
// Optional FCS checking is built when ETHER_RX_CRC_CHECK_EN is defined;
// otherwise every committed frame reports frm_crc_ok=1.
//
// state | meaning
// IDLE  | waiting for the first preamble byte
// PRE   | counting 0x55 bytes, waiting for SFD
// DATA  | storing bytes into the current write slot
// CHECK | one cycle: length check and commit or discard
// DROP  | ignoring bytes until dv falls
module ether_rx_frame_ctrl
    import ether_rx_pkg::*;
#(
    parameter int MIN_LEN = 64,
    parameter int MAX_LEN = 1518,
    parameter int PRE_MIN = 7
) (
    input  logic        phy_rx_clk,
    input  logic        rst,
    input  logic        phy_rx_dv,
    input  logic        phy_rx_er,
    input  logic [7:0]  phy_rx_data,
    output logic        buf_we,
    output logic [11:0] buf_waddr,
    output logic [7:0]  buf_wdata,
    output logic        frm_valid,
    output logic        frm_slot,
    output logic [10:0] frm_len,
    output logic        frm_crc_ok,
    input  logic        frm_ack,
    output logic [15:0] drop_cnt
);

    rx_state_t   state, state_nxt;
    logic [3:0]  pre_cnt, pre_cnt_nxt;
    logic [10:0] wr_ptr, wr_ptr_nxt;
    logic        wr_slot;
    logic [1:0]  occ;
    rx_desc_t    q [2];
    logic        q_wp, q_rp;

    logic        wr_en;
    logic        commit;
    logic        drop_evt;
    logic        crc_clr;
    logic        crc_ok;
    logic        pop;
    logic        slot_free;

    assign slot_free = (occ != 2'd2);
    // Ack is honoured only against a visible descriptor that is still queued.
    assign pop       = frm_ack && frm_valid && (occ != 2'd0);

`ifdef ETHER_RX_CRC_CHECK_EN
    logic [31:0] crc_reg;

    ether_rx_crc32 u_crc (
        .phy_rx_clk (phy_rx_clk),
        .rst        (rst),
        .clr        (crc_clr),
        .calc       (wr_en),
        .data       (phy_rx_data),
        .crc        (crc_reg)
    );

    assign crc_ok = (crc_reg == CRC_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    // Next-state and per-byte control decode.
    always_comb begin
        state_nxt   = state;
        pre_cnt_nxt = pre_cnt;
        wr_ptr_nxt  = wr_ptr;
        wr_en       = 1'b0;
        commit      = 1'b0;
        drop_evt    = 1'b0;
        crc_clr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (phy_rx_dv) begin
                    if (phy_rx_data == PRE_BYTE) begin
                        state_nxt   = ST_PRE;
                        pre_cnt_nxt = 4'd1;
                    end else begin
                        state_nxt = ST_DROP;
                    end
                end
            end
            ST_PRE: begin
                if (!phy_rx_dv) begin
                    state_nxt = ST_DROP;
                end else if (phy_rx_data == PRE_BYTE) begin
                    if (pre_cnt != 4'hF)
                        pre_cnt_nxt = pre_cnt + 4'd1;
                end else if (phy_rx_data == SFD && pre_cnt >= PRE_MIN[3:0]) begin
                    crc_clr = 1'b1;
                    if (slot_free) begin
                        state_nxt  = ST_DATA;
                        wr_ptr_nxt = 11'd0;
                    end else begin
                        // A real frame started with nowhere to put it.
                        state_nxt = ST_DROP;
                        drop_evt  = 1'b1;
                    end
                end else begin
                    state_nxt = ST_DROP;
                end
            end
            ST_DATA: begin
                if (!phy_rx_dv) begin
                    state_nxt = ST_CHECK;
                end else if (phy_rx_er || wr_ptr == MAX_LEN[10:0]) begin
                    state_nxt = ST_DROP;
                    drop_evt  = 1'b1;
                end else begin
                    wr_en      = 1'b1;
                    wr_ptr_nxt = wr_ptr + 11'd1;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_IDLE;
                if (wr_ptr < MIN_LEN[10:0])
                    drop_evt = 1'b1;
                else
                    commit = 1'b1;
            end
            ST_DROP: begin
                if (!phy_rx_dv)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, preamble counter, write pointer and write-slot selection.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            pre_cnt <= 4'd0;
            wr_ptr  <= 11'd0;
            wr_slot <= 1'b0;
        end else begin
            state   <= state_nxt;
            pre_cnt <= pre_cnt_nxt;
            wr_ptr  <= wr_ptr_nxt;
            if (commit)
                wr_slot <= ~wr_slot;
        end
    end

    // Registered buffer write port; address/data hold between writes.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst) begin
            buf_we    <= 1'b0;
            buf_waddr <= 12'd0;
            buf_wdata <= 8'd0;
        end else begin
            buf_we <= wr_en;
            if (wr_en) begin
                buf_waddr <= {wr_slot, wr_ptr};
                buf_wdata <= phy_rx_data;
            end
        end
    end

    // Descriptor queue: commit and pop may coincide, leaving occ unchanged.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst) begin
            q[0] <= '0;
            q[1] <= '0;
            q_wp <= 1'b0;
            q_rp <= 1'b0;
            occ  <= 2'd0;
        end else begin
            if (commit) begin
                q[q_wp] <= '{slot: wr_slot, len: wr_ptr, crc_ok: crc_ok};
                q_wp    <= ~q_wp;
            end
            if (pop)
                q_rp <= ~q_rp;
            case ({commit, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Registered view of the queue head for the consumer.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst) begin
            frm_valid  <= 1'b0;
            frm_slot   <= 1'b0;
            frm_len    <= 11'd0;
            frm_crc_ok <= 1'b0;
        end else begin
            frm_valid  <= (occ != 2'd0);
            frm_slot   <= q[q_rp].slot;
            frm_len    <= q[q_rp].len;
            frm_crc_ok <= q[q_rp].crc_ok;
        end
    end

    // Saturating discarded-frame counter.
    always_ff @(posedge phy_rx_clk or posedge rst) begin
        if (rst)
            drop_cnt <= 16'd0;
        else if (drop_evt && drop_cnt != 16'hFFFF)
            drop_cnt <= drop_cnt + 16'd1;
    end

endmodule

// File: tb/tb_ether_rx_frame_ctrl.sv
// Self-checking bench for ether_rx_frame_ctrl. Buffer writes and
// descriptors are checked against scoreboard queues filled as frames are
// driven. Honours ETHER_RX_CRC_CHECK_EN for the expected FCS status.
module tb_ether_rx_frame_ctrl;

    localparam int MAX_LEN = 1518;

`ifdef ETHER_RX_CRC_CHECK_EN
    localparam logic BAD_FCS_OK = 1'b0;
`else
    localparam logic BAD_FCS_OK = 1'b1;
`endif

    logic        phy_rx_clk = 1'b0;
    logic        rst;
    logic        phy_rx_dv;
    logic        phy_rx_er;
    logic [7:0]  phy_rx_data;
    logic        buf_we;
    logic [11:0] buf_waddr;
    logic [7:0]  buf_wdata;
    logic        frm_valid;
    logic        frm_slot;
    logic [10:0] frm_len;
    logic        frm_crc_ok;
    logic        frm_ack;
    logic [15:0] drop_cnt;

    int          total = 0;
    int          bad   = 0;
    int          wr_seen = 0;
    bit          sb_en = 1'b0;
    logic        exp_slot = 1'b0;
    int          exp_drop = 0;
    logic [19:0] exp_wr [$];
    logic [12:0] exp_dq [$];
    logic [7:0]  frm_bytes [$];
    logic [19:0] mon_exp;

    ether_rx_frame_ctrl dut (
        .phy_rx_clk  (phy_rx_clk),
        .rst         (rst),
        .phy_rx_dv   (phy_rx_dv),
        .phy_rx_er   (phy_rx_er),
        .phy_rx_data (phy_rx_data),
        .buf_we      (buf_we),
        .buf_waddr   (buf_waddr),
        .buf_wdata   (buf_wdata),
        .frm_valid   (frm_valid),
        .frm_slot    (frm_slot),
        .frm_len     (frm_len),
        .frm_crc_ok  (frm_crc_ok),
        .frm_ack     (frm_ack),
        .drop_cnt    (drop_cnt)
    );

    always #4 phy_rx_clk = ~phy_rx_clk;

    // Write monitor: every buffer write must match the next expected write.
    always @(negedge phy_rx_clk) begin
        if (sb_en && buf_we === 1'b1) begin
            wr_seen++;
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: addr=%h data=%h, required no write", buf_waddr, buf_wdata);
            end else begin
                mon_exp = exp_wr.pop_front();
                if ({buf_waddr, buf_wdata} !== mon_exp) begin
                    bad++;
                    $display("FAIL wr_data: addr/data=%h/%h, required %h/%h",
                             buf_waddr, buf_wdata, mon_exp[19:8], mon_exp[7:0]);
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic drive(input logic dv, input logic er, input logic [7:0] d);
        @(negedge phy_rx_clk);
        phy_rx_dv   = dv;
        phy_rx_er   = er;
        phy_rx_data = d;
    endtask

    // len-4 random bytes followed by a correct FCS; optionally corrupt one byte.
    task automatic build_frame(input int len, input bit corrupt);
        logic [31:0] c;
        frm_bytes.delete();
        for (int i = 0; i < len - 4; i++)
            frm_bytes.push_back(8'($urandom));
        c = 32'hFFFFFFFF;
        foreach (frm_bytes[i]) begin
            c = c ^ {24'd0, frm_bytes[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        c = ~c;
        frm_bytes.push_back(c[7:0]);
        frm_bytes.push_back(c[15:8]);
        frm_bytes.push_back(c[23:16]);
        frm_bytes.push_back(c[31:24]);
        if (corrupt)
            frm_bytes[10] = frm_bytes[10] ^ 8'h01;
    endtask

    // Preamble, SFD, frm_bytes, then dv low. Optional ack lands on the commit edge.
    task automatic send_frame(input int npre, input int er_at, input bit store, input bit ack_cc);
        for (int i = 0; i < npre; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < frm_bytes.size(); i++) begin
            drive(1'b1, (i == er_at), frm_bytes[i]);
            if (store && (er_at < 0 || i < er_at) && i < MAX_LEN)
                exp_wr.push_back({exp_slot, 11'(i), frm_bytes[i]});
        end
        drive(1'b0, 1'b0, 8'h00);
        @(negedge phy_rx_clk);
        frm_ack = ack_cc;
        @(negedge phy_rx_clk);
        frm_ack = 1'b0;
        repeat (4) @(negedge phy_rx_clk);
        total++;
        if (exp_wr.size() != 0) begin
            bad++;
            $display("FAIL wr_missing: %0d writes outstanding, required 0", exp_wr.size());
            exp_wr.delete();
        end
    endtask

    // Wait for a descriptor, compare it with the scoreboard head, then ack it.
    task automatic pop_desc(input string tag);
        logic [12:0] e;
        int n;
        n = 0;
        while (frm_valid !== 1'b1 && n < 20) begin
            @(negedge phy_rx_clk);
            n++;
        end
        e = (exp_dq.size() != 0) ? exp_dq.pop_front() : 13'h1FFF;
        total++;
        if (frm_valid !== 1'b1 || {frm_slot, frm_len, frm_crc_ok} !== e) begin
            bad++;
            $display("FAIL desc_%s: valid=%b slot=%b len=%0d ok=%b, required valid=1 slot=%b len=%0d ok=%b",
                     tag, frm_valid, frm_slot, frm_len, frm_crc_ok, e[12], e[11:1], e[0]);
        end
        frm_ack = 1'b1;
        @(negedge phy_rx_clk);
        frm_ack = 1'b0;
        repeat (2) @(negedge phy_rx_clk);
    endtask

    task automatic expect_commit(input logic ok);
        exp_dq.push_back({exp_slot, 11'(frm_bytes.size()), ok});
        exp_slot = ~exp_slot;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        phy_rx_dv = 1'b0; phy_rx_er = 1'b0; phy_rx_data = 8'h00; frm_ack = 1'b0;
        repeat (3) @(negedge phy_rx_clk);
        rst = 1'b0;
        sb_en = 1'b1;
        @(negedge phy_rx_clk);
        total++;
        if ({buf_we, buf_waddr, buf_wdata} !== 21'd0) begin
            bad++;
            $display("FAIL reset_buf: we=%b addr=%h data=%h, required 0", buf_we, buf_waddr, buf_wdata);
        end
        total++;
        if ({frm_valid, frm_slot, frm_len, frm_crc_ok} !== 14'd0) begin
            bad++;
            $display("FAIL reset_desc: valid=%b slot=%b len=%0d ok=%b, required 0",
                     frm_valid, frm_slot, frm_len, frm_crc_ok);
        end
        total++;
        if (drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_drop: drop_cnt=%0d, required 0", drop_cnt);
        end
    endtask

    task automatic test_basic();
        build_frame(64, 1'b0);
        send_frame(7, -1, 1'b1, 1'b0);
        expect_commit(1'b1);
        pop_desc("basic");
        total++;
        if (frm_valid !== 1'b0 || drop_cnt !== 16'(exp_drop)) begin
            bad++;
            $display("FAIL basic_after_ack: valid=%b drop=%0d, required valid=0 drop=%0d",
                     frm_valid, drop_cnt, exp_drop);
        end
    endtask

    task automatic test_no_slot();
        int w0;
        for (int f = 0; f < 2; f++) begin
            build_frame(100, 1'b0);
            send_frame(7, -1, 1'b1, 1'b0);
            expect_commit(1'b1);
        end
        build_frame(100, 1'b0);
        w0 = wr_seen;
        send_frame(7, -1, 1'b0, 1'b0);
        exp_drop++;
        total++;
        if (drop_cnt !== 16'(exp_drop) || wr_seen != w0) begin
            bad++;
            $display("FAIL no_slot_drop: drop=%0d writes=%0d, required drop=%0d writes=0",
                     drop_cnt, wr_seen - w0, exp_drop);
        end
        pop_desc("full_a");
        pop_desc("full_b");
        total++;
        if (frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL no_slot_empty: valid=%b, required 0", frm_valid);
        end
    endtask

    task automatic test_bad_fcs();
        build_frame(64, 1'b1);
        send_frame(7, -1, 1'b1, 1'b0);
        expect_commit(BAD_FCS_OK);
        pop_desc("bad_fcs");
    endtask

    task automatic test_drop_er_runt();
        build_frame(100, 1'b0);
        send_frame(7, 30, 1'b1, 1'b0);
        exp_drop++;
        total++;
        if (drop_cnt !== 16'(exp_drop) || frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL rx_er_drop: drop=%0d valid=%b, required drop=%0d valid=0",
                     drop_cnt, frm_valid, exp_drop);
        end
        build_frame(40, 1'b0);
        send_frame(7, -1, 1'b1, 1'b0);
        exp_drop++;
        total++;
        if (drop_cnt !== 16'(exp_drop) || frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL runt_drop: drop=%0d valid=%b, required drop=%0d valid=0",
                     drop_cnt, frm_valid, exp_drop);
        end
    endtask

    task automatic test_overlength();
        int w0;
        build_frame(1600, 1'b0);
        w0 = wr_seen;
        send_frame(7, -1, 1'b1, 1'b0);
        exp_drop++;
        total++;
        if (wr_seen - w0 != MAX_LEN || drop_cnt !== 16'(exp_drop) || frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL overlength: writes=%0d drop=%0d valid=%b, required writes=%0d drop=%0d valid=0",
                     wr_seen - w0, drop_cnt, frm_valid, MAX_LEN, exp_drop);
        end
    endtask

    task automatic test_short_pre();
        build_frame(64, 1'b0);
        send_frame(6, -1, 1'b0, 1'b0);
        total++;
        if (drop_cnt !== 16'(exp_drop) || frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL short_pre: drop=%0d valid=%b, required drop=%0d valid=0",
                     drop_cnt, frm_valid, exp_drop);
        end
        build_frame(64, 1'b0);
        send_frame(15, -1, 1'b1, 1'b0);
        expect_commit(1'b1);
        pop_desc("long_pre");
    endtask

    task automatic test_back_to_back();
        logic [12:0] old_head;
        build_frame(64, 1'b0);
        send_frame(7, -1, 1'b1, 1'b0);
        expect_commit(1'b1);
        build_frame(80, 1'b0);
        send_frame(7, -1, 1'b1, 1'b1);
        old_head = exp_dq.pop_front();
        expect_commit(1'b1);
        total++;
        if (frm_slot === old_head[12]) begin
            bad++;
            $display("FAIL b2b_advance: slot=%b, required %b", frm_slot, ~old_head[12]);
        end
        pop_desc("b2b");
        total++;
        if (frm_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_occ: valid=%b after single ack, required 0", frm_valid);
        end
    endtask

    task automatic test_reset_mid();
        build_frame(64, 1'b0);
        send_frame(7, -1, 1'b1, 1'b0);
        expect_commit(1'b1);
        sb_en = 1'b0;
        build_frame(100, 1'b0);
        for (int i = 0; i < 7; i++)
            drive(1'b1, 1'b0, 8'h55);
        drive(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 20; i++)
            drive(1'b1, 1'b0, frm_bytes[i]);
        rst = 1'b1;
        #1;
        total++;
        if ({buf_we, buf_waddr, buf_wdata, frm_valid, frm_slot, frm_len, frm_crc_ok, drop_cnt} !== 51'd0) begin
            bad++;
            $display("FAIL reset_mid: we=%b addr=%h valid=%b slot=%b len=%0d ok=%b drop=%0d, required all 0",
                     buf_we, buf_waddr, frm_valid, frm_slot, frm_len, frm_crc_ok, drop_cnt);
        end
        drive(1'b0, 1'b0, 8'h00);
        @(negedge phy_rx_clk);
        rst = 1'b0;
        exp_dq.delete();
        exp_wr.delete();
        exp_slot = 1'b0;
        exp_drop = 0;
        repeat (2) @(negedge phy_rx_clk);
        sb_en = 1'b1;
        total++;
        if (frm_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid_after: valid=%b drop=%0d, required 0/0", frm_valid, drop_cnt);
        end
        build_frame(64, 1'b0);
        send_frame(7, -1, 1'b1, 1'b0);
        expect_commit(1'b1);
        pop_desc("post_reset");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_slot();
        test_bad_fcs();
        test_drop_er_runt();
        test_overlength();
        test_short_pre();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
